// File: rtl/fourbit_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock with a
// start/busy/done handshake. A zero divisor short-circuits straight to DONE.
module fourbit_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   s;
  logic             ge;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  // The partial remainder is always below d after a step, so only the shifted
  // value s needs the extra bit; the difference itself fits in WIDTH bits.
  always_comb begin
    s      = {r, q[WIDTH-1]};
    ge     = (s >= {1'b0, d});
    r_next = ge ? (s[WIDTH-1:0] - d) : s[WIDTH-1:0];
    q_next = {q[WIDTH-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              r     <= '0;
              q     <= dividend;
              d     <= divisor;
              count <= '0;
              busy  <= 1'b1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          r     <= r_next;
          q     <= q_next;
          count <= count + 1'b1;
          if (count == LAST_ITER) begin
            quotient    <= q_next;
            remainder   <= r_next;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fourbit_divider.sv
// Scoreboard bench for fourbit_divider: stimulus pushes expected results,
// a forked monitor pops and compares on every done pulse.
module tb_fourbit_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  fourbit_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int unsigned cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    int          q;
    int          r;
    int          dz;
    int unsigned doneEdge;
  } exp_t;

  exp_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;
  bit   checkSpacing = 1'b0;
  bit   havePrev     = 1'b0;
  int unsigned prevDone = 0;

  task automatic checkOutput(input string name, input int actual, input int required);
    compared++;
    if (actual != required) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, required, cycle);
    end
  endtask

  // Plain arithmetic reference: a/b and a%b, or the zero-divisor rule.
  function automatic exp_t model(input int a, input int b, input int unsigned acceptEdge);
    exp_t e;
    if (b == 0) begin
      e.q = (1 << W) - 1;
      e.r = a;
      e.dz = 1;
      e.doneEdge = acceptEdge;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.dz = 0;
      e.doneEdge = acceptEdge + W;
    end
    return e;
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        checkOutput("busy_with_done", int'(busy), 0);
        checkOutput("done_expected", int'(expQ.size() > 0), 1);
        if (expQ.size() > 0) begin
          e = expQ.pop_front();
          checkOutput("quotient", int'(quotient), e.q);
          checkOutput("remainder", int'(remainder), e.r);
          checkOutput("div_by_zero", int'(div_by_zero), e.dz);
          checkOutput("done_cycle", int'(cycle), int'(e.doneEdge));
          if (checkSpacing && havePrev)
            checkOutput("done_spacing", int'(cycle - prevDone), (e.dz != 0) ? 2 : W + 2);
          prevDone = cycle;
          havePrev = 1'b1;
        end
      end
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic applyStimulus(input int a, input int b, input bit holdStart);
    int n;
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    expQ.push_back(model(a, b, cycle + 1));
    @(posedge clk);
    @(negedge clk);
    checkOutput("busy_after_accept", int'(busy), int'(b != 0));
    if (holdStart) begin
      dividend = 4'd6;
      divisor  = 4'd2;
    end else begin
      start = 1'b0;
    end
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_timeout", int'(done), 1);
    if (!done) expQ.delete();
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    fork
      monitor();
    join_none
    #1;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_quotient", int'(quotient), 0);
    checkOutput("reset_remainder", int'(remainder), 0);
    checkOutput("reset_dbz", int'(div_by_zero), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(13, 3, 1'b0);
    applyStimulus(15, 1, 1'b0);
    applyStimulus(7, 9, 1'b0);
    applyStimulus(0, 5, 1'b0);
    applyStimulus(15, 15, 1'b0);
    applyStimulus(9, 0, 1'b0);
    applyStimulus(8, 2, 1'b0);

    // start held high with new operands during CALC must not trigger a second divide
    applyStimulus(13, 3, 1'b1);
    repeat (8) @(negedge clk);
    checkOutput("hold_quotient", int'(quotient), 4);
    checkOutput("hold_remainder", int'(remainder), 1);
    checkOutput("hold_no_pending", expQ.size(), 0);

    // abort mid-CALC
    dividend = 4'd14;
    divisor  = 4'd3;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_done", int'(done), 0);
    checkOutput("abort_quotient", int'(quotient), 0);
    checkOutput("abort_remainder", int'(remainder), 0);
    checkOutput("abort_dbz", int'(div_by_zero), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(14, 3, 1'b0);

    for (int i = 0; i < 40; i++)
      applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b0);

    checkSpacing = 1'b1;
    havePrev = 1'b0;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        applyStimulus(a, b, 1'b0);
    checkSpacing = 1'b0;

    repeat (5) @(negedge clk);
    checkOutput("queue_drained", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
